// File: rtl/tpm_bus_arbiter.sv
// Two-port TPM register-file arbiter: LPC (port 0) and SPI (port 1) share one access port.
// Writes are queued per port; reads stall the front-end until the register file answers.

module tpm_arb_port #(
    parameter int WR_DEPTH    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        active,
    input  logic        wr,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        pop,
    output logic        act,
    output logic        act_rise,
    output logic        act_fall,
    output logic        req_rise,
    output logic        empty,
    output logic        drop,
    output logic [23:0] head
);
    localparam int AW = (WR_DEPTH > 1) ? $clog2(WR_DEPTH) : 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_ent_t;

    logic [SYNC_STAGES-1:0] act_sync, wr_sync, req_sync;
    logic [2:0]             prev_q;
    logic                   wr_s, req_s, wr_rise, full, push;
    wr_ent_t                mem [WR_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [AW:0]            count;

    assign act      = act_sync[SYNC_STAGES-1];
    assign wr_s     = wr_sync[SYNC_STAGES-1];
    assign req_s    = req_sync[SYNC_STAGES-1];
    assign act_rise = act & ~prev_q[2];
    assign act_fall = ~act & prev_q[2];
    assign wr_rise  = wr_s & ~prev_q[1];
    assign req_rise = req_s & ~prev_q[0];

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(WR_DEPTH));
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted then.
    assign push  = wr_rise & (~full | pop);
    assign drop  = wr_rise & full & ~pop;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            act_sync <= '0;
            wr_sync  <= '0;
            req_sync <= '0;
            prev_q   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            act_sync[0] <= active;
            wr_sync[0]  <= wr;
            req_sync[0] <= req;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                act_sync[k] <= act_sync[k-1];
                wr_sync[k]  <= wr_sync[k-1];
                req_sync[k] <= req_sync[k-1];
            end
            prev_q <= {act, wr_s, req_s};
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= '{addr: addr, data: wdata};
    end
endmodule

module tpm_bus_arbiter #(
    parameter int WR_DEPTH    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  p_active_i,
    input  logic [31:0] p_addr_i,
    input  logic [15:0] p_wdata_i,
    input  logic [1:0]  p_wr_i,
    output logic [1:0]  p_wr_done_o,
    input  logic [1:0]  p_req_i,
    output logic [1:0]  p_rd_o,
    output logic [15:0] p_rdata_o,
    output logic [1:0]  p_ovf_o,
    output logic [1:0]  owner_o,
    output logic [15:0] reg_addr_o,
    output logic [7:0]  reg_wdata_o,
    output logic        reg_wr_o,
    output logic        reg_rd_o,
    input  logic [7:0]  reg_rdata_i,
    input  logic        reg_done_i
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        act, act_rise, act_fall, req_rise, empty, drop, pop, req_g, grant;
    logic [1:0][23:0]  head;
    logic [1:0]        owner_q, owner_d, rd_pend_q, rd_pend_d, rd_q, rd_d;
    logic [1:0]        ovf_q, ovf_d, wr_done_q, wr_done_d;
    logic [1:0][7:0]   rdata_q, rdata_d;
    logic              last_q, last_d, o, release_g, tmo_fire, issuing;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [15:0]       addr_q, issue_addr;
    logic [7:0]        wdata_q, issue_wdata;

    for (genvar g = 0; g < 2; g++) begin : g_port
        tpm_arb_port #(.WR_DEPTH(WR_DEPTH), .SYNC_STAGES(SYNC_STAGES)) u_port (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .active   (p_active_i[g]),
            .wr       (p_wr_i[g]),
            .req      (p_req_i[g]),
            .addr     (p_addr_i[16*g +: 16]),
            .wdata    (p_wdata_i[8*g +: 8]),
            .pop      (pop[g]),
            .act      (act[g]),
            .act_rise (act_rise[g]),
            .act_fall (act_fall[g]),
            .req_rise (req_rise[g]),
            .empty    (empty[g]),
            .drop     (drop[g]),
            .head     (head[g])
        );
    end

    assign o         = owner_q[1];
    // A port with queued writes keeps asking for the bus even after its frame ended.
    assign req_g     = act | ~empty;
    assign release_g = (owner_q != 2'b00) && !act[o] && empty[o] && (state_q == IDLE);
    assign tmo_fire  = (tmo_q == TW'(TIMEOUT));

    assign issuing     = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
    assign issue_addr  = (state_q == WR_ISSUE) ? head[o][23:8]
                                               : (o ? p_addr_i[31:16] : p_addr_i[15:0]);
    assign issue_wdata = (state_q == WR_ISSUE) ? head[o][7:0] : wdata_q;

    assign reg_wr_o    = (state_q == WR_ISSUE);
    assign reg_rd_o    = (state_q == RD_ISSUE);
    assign reg_addr_o  = issuing ? issue_addr : addr_q;
    assign reg_wdata_o = issuing ? issue_wdata : wdata_q;
    assign owner_o     = owner_q;
    assign p_rd_o      = rd_q;
    assign p_rdata_o   = rdata_q;
    assign p_ovf_o     = ovf_q;
    assign p_wr_done_o = wr_done_q;

    always_comb begin
        state_d   = state_q;
        pop       = '0;
        tmo_d     = tmo_q;
        rd_pend_d = (rd_pend_q | req_rise) & ~act_fall;
        rd_d      = rd_q & ~req_rise;
        rdata_d   = rdata_q;
        ovf_d     = ovf_q;
        wr_done_d = '0;
        owner_d   = owner_q;
        last_d    = last_q;
        grant     = '0;

        if (owner_q == 2'b00) begin
            grant = (req_g == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req_g;
            if (grant != 2'b00) begin
                owner_d = grant;
                last_d  = grant[1];
                rd_d    = rd_d & ~grant;
                ovf_d   = ovf_d & ~(grant & act_rise);
            end
        end else if (release_g) begin
            owner_d = '0;
        end
        ovf_d = ovf_d | drop;

        case (state_q)
            IDLE: begin
                if (owner_q != 2'b00) begin
                    if (!empty[o])                  state_d = WR_ISSUE;
                    else if (rd_pend_q[o] && act[o]) state_d = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                pop[o]  = 1'b1;
                tmo_d   = '0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (reg_done_i) begin
                    wr_done_d[o] = 1'b1;
                    state_d      = IDLE;
                end else if (tmo_fire) begin
                    ovf_d[o] = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RD_ISSUE: begin
                rd_pend_d[o] = 1'b0;
                tmo_d        = '0;
                state_d      = RD_WAIT;
            end
            RD_WAIT: begin
                if (reg_done_i) begin
                    rdata_d[o] = reg_rdata_i;
                    rd_d[o]    = 1'b1;
                    state_d    = IDLE;
                end else if (tmo_fire) begin
                    rdata_d[o] = 8'hFF;
                    rd_d[o]    = 1'b1;
                    ovf_d[o]   = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= 1'b1;
            rd_pend_q <= '0;
            rd_q      <= '0;
            rdata_q   <= '0;
            ovf_q     <= '0;
            wr_done_q <= '0;
            tmo_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_q      <= rd_d;
            rdata_q   <= rdata_d;
            ovf_q     <= ovf_d;
            wr_done_q <= wr_done_d;
            tmo_q     <= tmo_d;
            if (issuing) begin
                addr_q  <= issue_addr;
                wdata_q <= issue_wdata;
            end
        end
    end
endmodule

// File: tb/tb_tpm_bus_arbiter.sv
// Directed bench for tpm_bus_arbiter: auto-responding register file, strobe log, hand-computed checks.

module tb_tpm_bus_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [1:0]  p_active_i;
    logic [31:0] p_addr_i;
    logic [15:0] p_wdata_i;
    logic [1:0]  p_wr_i;
    logic [1:0]  p_wr_done_o;
    logic [1:0]  p_req_i;
    logic [1:0]  p_rd_o;
    logic [15:0] p_rdata_o;
    logic [1:0]  p_ovf_o;
    logic [1:0]  owner_o;
    logic [15:0] reg_addr_o;
    logic [7:0]  reg_wdata_o;
    logic        reg_wr_o;
    logic        reg_rd_o;
    logic [7:0]  reg_rdata_i;
    logic        reg_done_i;

    logic        resp_en, resp_done, man_done;
    logic [23:0] wlog[$];
    logic [15:0] rlog[$];
    bit          ord[$];
    int          dn0, dn1;
    int          n_chk, n_pass;

    tpm_bus_arbiter #(.WR_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(64)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .p_active_i  (p_active_i),
        .p_addr_i    (p_addr_i),
        .p_wdata_i   (p_wdata_i),
        .p_wr_i      (p_wr_i),
        .p_wr_done_o (p_wr_done_o),
        .p_req_i     (p_req_i),
        .p_rd_o      (p_rd_o),
        .p_rdata_o   (p_rdata_o),
        .p_ovf_o     (p_ovf_o),
        .owner_o     (owner_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wr_o    (reg_wr_o),
        .reg_rd_o    (reg_rd_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_done_i  (reg_done_i)
    );

    always #5 clk_i = ~clk_i;
    assign reg_done_i = resp_done | man_done;

    // Register-file model: answers each strobe a fixed few cycles later.
    initial resp_done = 1'b0;
    always begin
        @(negedge clk_i);
        if (rst_n_i && resp_en && (reg_wr_o || reg_rd_o)) begin
            repeat (2) @(negedge clk_i);
            resp_done = 1'b1;
            @(negedge clk_i);
            resp_done = 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (reg_wr_o) begin wlog.push_back({reg_addr_o, reg_wdata_o}); ord.push_back(1'b0); end
            if (reg_rd_o) begin rlog.push_back(reg_addr_o); ord.push_back(1'b1); end
            if (p_wr_done_o[0]) dn0++;
            if (p_wr_done_o[1]) dn1++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wr_byte(input int p, input logic [15:0] a, input logic [7:0] d);
        p_addr_i[16*p +: 16] = a;
        p_wdata_i[8*p +: 8]  = d;
        p_wr_i[p] = 1'b1;
        tick(4);
        p_wr_i[p] = 1'b0;
        tick(4);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_owner"}, 32'(owner_o), 32'h0);
        chk({tag, "_rd"}, 32'(p_rd_o), 32'h0);
        chk({tag, "_wrdone"}, 32'(p_wr_done_o), 32'h0);
        chk({tag, "_ovf"}, 32'(p_ovf_o), 32'h0);
        chk({tag, "_strb"}, 32'({reg_wr_o, reg_rd_o}), 32'h0);
        chk({tag, "_addr"}, 32'({reg_addr_o, reg_wdata_o}), 32'h0);
        chk({tag, "_rdata"}, 32'(p_rdata_o), 32'h0);
    endtask

    initial begin
        int base, rbase, c, lat;
        bit ok;
        logic [7:0] bytes1 [4];
        logic [7:0] bytes2 [5];
        bytes1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        bytes2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        n_chk = 0; n_pass = 0; dn0 = 0; dn1 = 0;
        rst_n_i = 1'b0; p_active_i = '0; p_addr_i = '0; p_wdata_i = '0;
        p_wr_i = '0; p_req_i = '0; reg_rdata_i = '0; resp_en = 1'b1; man_done = 1'b0;
        tick(3);
        chk_all_zero("reset");
        rst_n_i = 1'b1;
        tick(2);

        // SPI burst of four writes to 0xD40018
        p_active_i[1] = 1'b1;
        tick(6);
        chk("t1_owner", 32'(owner_o), 32'h2);
        foreach (bytes1[k]) wr_byte(1, 16'h0018, bytes1[k]);
        tick(20);
        chk("t1_nwr", wlog.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < wlog.size()) chk($sformatf("t1_wr%0d", k), 32'(wlog[k]), {8'h0, 16'h0018, bytes1[k]});
        chk("t1_done", dn1, 4);
        chk("t1_ovf", 32'(p_ovf_o), 32'h0);
        p_active_i[1] = 1'b0;
        tick(8);
        chk("t1_release", 32'(owner_o), 32'h0);

        // Port 0 holds the bus while port 1 overfills its queue
        p_active_i[0] = 1'b1;
        tick(6);
        chk("t2_owner0", 32'(owner_o), 32'h1);
        p_active_i[1] = 1'b1;
        base = wlog.size();
        foreach (bytes2[k]) wr_byte(1, 16'h0020, bytes2[k]);
        chk("t2_queued", wlog.size(), base);
        chk("t2_ovf", 32'(p_ovf_o), 32'h2);
        chk("t2_owner_held", 32'(owner_o), 32'h1);
        p_active_i[0] = 1'b0;
        tick(8);
        chk("t2_owner1", 32'(owner_o), 32'h2);
        tick(30);
        chk("t2_nwr", wlog.size() - base, 4);
        for (int k = 0; k < 4; k++)
            if (base + k < wlog.size()) chk($sformatf("t2_wr%0d", k), 32'(wlog[base+k]), {8'h0, 16'h0020, bytes2[k]});
        chk("t2_done", dn1, 8);
        p_active_i[1] = 1'b0;
        tick(8);

        // Write then read on port 1: write must reach the register file first
        reg_rdata_i = 8'hD1;
        p_active_i[1] = 1'b1;
        tick(6);
        chk("t3_owner", 32'(owner_o), 32'h2);
        chk("t3_ovf_clr", 32'(p_ovf_o), 32'h0);
        base = ord.size();
        p_addr_i[31:16] = 16'h0F00;
        p_wdata_i[15:8] = 8'h5A;
        p_wr_i[1] = 1'b1;
        tick(1);
        p_req_i[1] = 1'b1;
        tick(20);
        chk("t3_nev", ord.size() - base, 2);
        if (ord.size() >= base + 2) chk("t3_order", 32'({ord[base], ord[base+1]}), 32'h1);
        if (rlog.size() > 0) chk("t3_raddr", 32'(rlog[rlog.size()-1]), 32'h0F00);
        if (wlog.size() > 0) chk("t3_wr", 32'(wlog[wlog.size()-1]), 32'h0F005A);
        chk("t3_rd", 32'(p_rd_o), 32'h2);
        chk("t3_rdata", 32'(p_rdata_o[15:8]), 32'hD1);
        p_req_i[1] = 1'b0; p_wr_i[1] = 1'b0;
        tick(6);
        chk("t3_rd_hold", 32'(p_rd_o[1]), 32'h1);
        p_active_i[1] = 1'b0;
        tick(8);

        // Simultaneous frames: alternate starting from port 0 after reset
        rst_n_i = 1'b0; tick(2); rst_n_i = 1'b1; tick(2);
        p_active_i = 2'b11;
        tick(6);
        chk("t4_first", 32'(owner_o), 32'h1);
        p_active_i = 2'b00;
        tick(8);
        chk("t4_idle", 32'(owner_o), 32'h0);
        p_active_i = 2'b11;
        tick(6);
        chk("t4_second", 32'(owner_o), 32'h2);
        p_active_i = 2'b00;
        tick(8);

        // Read that the register file never answers
        resp_en = 1'b0;
        p_active_i[0] = 1'b1;
        p_addr_i[15:0] = 16'h0100;
        tick(6);
        chk("t5_owner", 32'(owner_o), 32'h1);
        p_req_i[0] = 1'b1;
        ok = 1'b0;
        for (c = 0; c < 20 && !ok; c++) begin tick(1); ok = reg_rd_o; end
        chk("t5_strobe", 32'(ok), 32'h1);
        lat = 0; ok = 1'b0;
        while (lat < 150 && !ok) begin tick(1); lat++; ok = p_rd_o[0]; end
        chk("t5_rd", 32'(ok), 32'h1);
        chk("t5_lat", 32'(lat >= 65 && lat <= 67), 32'h1);
        chk("t5_rdata", 32'(p_rdata_o[7:0]), 32'hFF);
        chk("t5_ovf", 32'(p_ovf_o[0]), 32'h1);

        // Reset in the middle of a read; a late completion must be ignored
        p_req_i[0] = 1'b0;
        tick(4);
        p_req_i[0] = 1'b1;
        ok = 1'b0;
        for (c = 0; c < 20 && !ok; c++) begin tick(1); ok = reg_rd_o; end
        chk("t6_strobe", 32'(ok), 32'h1);
        tick(3);
        rbase = rlog.size();
        rst_n_i = 1'b0; p_active_i = '0; p_req_i = '0;
        #1;
        chk_all_zero("t6_rst");
        tick(2);
        rst_n_i = 1'b1;
        tick(3);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(10);
        chk("t6_no_rd", 32'(p_rd_o), 32'h0);
        chk("t6_owner", 32'(owner_o), 32'h0);
        chk("t6_no_reissue", rlog.size(), rbase);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tpm_bus_arbiter.md
Name: tpm_bus_arbiter

Overview:
- Shares one TPM register-file access port between two bus front-ends: port 0 is the LPC peripheral, port 1 is the SPI peripheral.
- Sits in the system clock domain, between the front-ends' data-provider interfaces and the register module.
- Grants one port per bus transaction.
- Buffers writes from either port so they are never lost; the SPI front-end has no write flow control.
- Stalls reads through the front-end read-ready (wait-state) handshake.

Parameters:
WR_DEPTH, 4, write FIFO entries per port; max TPM access after 4B trim. Must be a power of 2.
SYNC_STAGES, 2, flop stages on each asynchronous control input (active, wr, req).
TIMEOUT, 64, clk_i cycles to wait for reg_done_i before aborting a register access.

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
p_active_i  input  2  per port: transaction in progress (front-end chip select/frame active)
p_addr_i  input  32  per port 16-bit TPM address; port i at [16i+15:16i]
p_wdata_i  input  16  per port write byte; port i at [8i+7:8i]
p_wr_i  input  2  per port write strobe; rising edge = new byte on p_wdata_i
p_wr_done_o  output  2  per port 1-cycle pulse when that port's write is committed to the register file
p_req_i  input  2  per port read request; rising edge = byte requested
p_rd_o  output  2  per port read data valid (front-end data_rd)
p_rdata_o  output  16  per port read byte; port i at [8i+7:8i]
p_ovf_o  output  2  per port sticky overflow/timeout error
owner_o  output  2  one-hot current grant; 0 = none
reg_addr_o  output  16  register-file address
reg_wdata_o  output  8  register-file write data
reg_wr_o  output  1  1-cycle write strobe
reg_rd_o  output  1  1-cycle read strobe
reg_rdata_i  input  8  read data, valid with reg_done_i
reg_done_i  input  1  1-cycle completion for either access

Behaviour:
- Reset (async, rst_n_i=0): FSM IDLE; FIFOs empty; synchronisers cleared.
  - All outputs 0: owner_o, p_rd_o, p_wr_done_o, p_ovf_o, reg_* strobes, reg_addr_o, reg_wdata_o, p_rdata_o.
  - Reset mid-access abandons the access; no strobe is reissued.
- Control inputs: p_active_i, p_wr_i and p_req_i each pass through SYNC_STAGES flops. Edges are detected on the synchronised value.
- Write capture:
  - On a synced rising edge of p_wr_i[i], push {p_addr_i, p_wdata_i} for port i. Push happens the same cycle, regardless of grant.
  - Push to a full FIFO: drop the byte and set p_ovf_o[i].
- Read request: a synced rising edge of p_req_i[i] clears p_rd_o[i] and sets rd_pend[i].
- Grant:
  - When owner_o=0, grant the port whose synced active rose.
  - If both are active in the same cycle, grant the port not granted last. After reset, port 0 wins.
  - Grant held until synced active[i]=0 AND FIFO[i] empty AND FSM IDLE.
  - The ungranted port's writes queue; its reads stall with p_rd_o=0, so the front-end inserts wait states.
  - A new grant on the rising edge of p_active_i clears p_ovf_o for that port.
- Service FSM (owner's port only):
  - IDLE -> WR_ISSUE if FIFO[owner] is non-empty; else -> RD_ISSUE if rd_pend[owner]. Writes always drain before a read, preserving program order.
  - WR_ISSUE: reg_wr_o=1 for 1 cycle with FIFO head on reg_addr_o/reg_wdata_o; pop; -> WR_WAIT.
  - WR_WAIT:
    - reg_done_i -> p_wr_done_o[owner] pulse, -> IDLE.
    - Timeout -> set p_ovf_o, -> IDLE.
  - RD_ISSUE: reg_rd_o=1 for 1 cycle, reg_addr_o=p_addr_i[owner]; clear rd_pend; -> RD_WAIT.
  - RD_WAIT:
    - reg_done_i -> p_rdata_o[owner]=reg_rdata_i, p_rd_o[owner]=1, -> IDLE.
    - Timeout -> p_rdata_o=8'hFF, p_rd_o=1, set p_ovf_o, -> IDLE.
  - Timeout counter: ceil(log2(TIMEOUT+1)) bits, cleared on entry to each WAIT state; fires when count==TIMEOUT.
- Latency: a synced strobe edge arriving with FSM IDLE and the port granted produces reg_wr_o/reg_rd_o exactly 2 cycles later (capture, then issue).
- Boundary conditions:
  - Synced active falls with rd_pend set: discard the read. Queued writes still drain.
  - reg_done_i outside a WAIT state is ignored.
  - Push and pop on the same entry in the same cycle are both honoured; the count is unchanged.
  - FIFO pointers wrap modulo WR_DEPTH.
  - p_rd_o stays 1 until the next req rising edge or a new grant.

Test Plan:
- Reset, port 1 active, 4 SPI writes to 0xD40018 (bytes 11,22,33,44); reg_done_i 3 cycles after each strobe -> reg_wr_o x4, same order, addr 0x0018; 4 p_wr_done_o[1] pulses; ovf=0.
- Port 0 holds grant mid-read; port 1 writes 5 bytes -> first 4 queued, 5th dropped, p_ovf_o[1]=1. After port 0 releases, owner_o=2'b10 and 4 writes issue.
- Port 1 write then read at 0x0F00 (reg_rdata_i=0xD1) -> reg_wr_o precedes reg_rd_o; p_rd_o[1]=1, p_rdata_o[15:8]=0xD1.
- Both actives rise in the same cycle after reset -> owner_o=2'b01. Next simultaneous rise -> 2'b10.
- Read with reg_done_i never asserted -> after 64 cycles, p_rdata_o=0xFF, p_rd_o=1, p_ovf_o set.
- rst_n_i low during RD_WAIT -> all outputs 0 immediately. After release, a late reg_done_i causes no p_rd_o.
